memoria_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's memory command interface.
- The CPU control FSM drives `req`, `memWriteOrRead` and `address`, then waits.
- This block accepts one command at a time, counts a fixed configurable latency, then commits the write or returns read data with a one-cycle `ready` pulse.
- It sits between the CPU datapath (PC/ALUOut address mux, B register, MDR/IR) and a word-organised on-chip RAM.

---
 rtl/memoria_pkg.sv | 16 +
 rtl/ram_palavra.sv | 26 ++
 rtl/memoria_responder.sv | 102 ++++++++++
 tb/tb_memoria_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Shared types and constants for the memory responder and its RAM.
package memoria_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } estado_mem_t;

    // Matches the CPU memWriteOrRead encoding.
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int LAT_W = 4;

endpackage

// File: rtl/ram_palavra.sv
// Single-port word RAM: synchronous write, registered read.
module ram_palavra #(
    parameter int    DEPTH_LOG2 = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic                  readEn,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           writeData,
    output logic [31:0]           readData
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // NOTE: the array has no reset branch; clearing a RAM on reset would
    // force it into flops and the contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (writeEn) mem[addr] <= writeData;
    end

    always_ff @(posedge clk) begin
        if (readEn) readData <= mem[addr];
    end

endmodule

// File: rtl/memoria_responder.sv
// Memory-side responder for the multicycle CPU: accepts one command, waits a
// fixed latency, then commits the write or returns read data with a ready pulse.
module memoria_responder
    import memoria_pkg::*;
#(
    parameter int    DEPTH_LOG2 = 8,
    parameter int    READ_LAT   = 2,
    parameter int    WRITE_LAT  = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memWriteOrRead,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [1:0]  estado
);

    localparam logic [LAT_W-1:0] READ_LOAD  = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0] WRITE_LOAD = LAT_W'(WRITE_LAT - 1);

    estado_mem_t      state, nextState;
    logic [LAT_W-1:0] cnt;
    logic             opQ;
    logic [31:0]      addrQ, wdataQ;
    logic             readyQ, errQ, zeroQ;
    logic [31:0]      ramQ;
    logic             accept, enterResp, addrErr;

    assign addrErr = (addrQ[1:0] != 2'b00) || (addrQ[31:DEPTH_LOG2+2] != '0);

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        enterResp = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept    = 1'b1;
                nextState = WAIT;
            end
            WAIT: if (cnt == '0) begin
                enterResp = 1'b1;
                nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: every register here uses <=, so all of them see the pre-edge
    // values of state and cnt regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            opQ    <= MEM_READ;
            addrQ  <= '0;
            wdataQ <= '0;
            readyQ <= 1'b0;
            errQ   <= 1'b0;
            zeroQ  <= 1'b1;
        end else begin
            state  <= nextState;
            readyQ <= enterResp;
            errQ   <= enterResp && addrErr;
            if (accept) begin
                opQ    <= memWriteOrRead;
                addrQ  <= address;
                wdataQ <= wdata;
                cnt    <= (memWriteOrRead == MEM_WRITE) ? WRITE_LOAD : READ_LOAD;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
            // rdata is masked to zero until the next completed good read.
            if (enterResp && opQ == MEM_READ) zeroQ <= addrErr;
        end
    end

    ram_palavra #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk      (clk),
        .writeEn  (enterResp && opQ == MEM_WRITE && !addrErr && !reset),
        .readEn   (enterResp && opQ == MEM_READ),
        .addr     (addrQ[DEPTH_LOG2+1:2]),
        .writeData(wdataQ),
        .readData (ramQ)
    );

    assign rdata  = zeroQ ? '0 : ramQ;
    assign ready  = readyQ;
    assign err    = errQ;
    assign busy   = (state != IDLE);
    assign estado = state;

endmodule

// File: tb/tb_memoria_responder.sv
// Randomized scoreboard bench for memoria_responder against a word-array model.
module tb_memoria_responder;

    localparam int DL = 8;
    localparam int RL = 2;
    localparam int WL = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        memWriteOrRead = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready, err, busy;
    logic [1:0]  estado;

    always #5 clk = ~clk;

    memoria_responder #(
        .DEPTH_LOG2(DL),
        .READ_LAT  (RL),
        .WRITE_LAT (WL),
        .INIT_FILE ("")
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .memWriteOrRead(memWriteOrRead),
        .address       (address),
        .wdata         (wdata),
        .rdata         (rdata),
        .ready         (ready),
        .err           (err),
        .busy          (busy),
        .estado        (estado)
    );

    typedef struct {
        bit          isWrite;
        bit          err;
        logic [31:0] rdata;
        int          readyCyc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] model[256];
    logic [31:0] lastRd = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: 1 KiB of words; any byte address not a multiple of 4 or
    // beyond the last word is an error, and only good reads change rdata.
    function automatic exp_t predict(input bit isWr, input logic [31:0] a,
                                     input logic [31:0] d, input int acc);
        exp_t e;
        int   w;
        w = int'((a >> 2) & 32'd255);
        e.isWrite = isWr;
        e.err     = (a % 4 != 0) || (a >= 32'd1024);
        if (isWr) begin
            if (!e.err) model[w] = d;
        end else begin
            lastRd = e.err ? 32'd0 : model[w];
        end
        e.rdata    = lastRd;
        e.readyCyc = acc + (isWr ? WL : RL);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && ready) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got ready=1 want no response pending (cycle %0d)", cyc);
            end else begin
                e = expQ.pop_front();
                check(e.isWrite ? "wr_err" : "rd_err", 32'(err), 32'(e.err));
                check(e.isWrite ? "wr_rdata_held" : "rd_rdata", rdata, e.rdata);
                check("ready_cycle", cyc, e.readyCyc);
            end
        end
    end

    task automatic waitReady(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no ready want ready within 40 cycles", name);
        end
    endtask

    task automatic doCmd(input bit isWr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1;
        memWriteOrRead = isWr;
        address = a;
        wdata = d;
        expQ.push_back(predict(isWr, a, d, cyc + 1));
        @(posedge clk);
        #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (!ready) waitReady("cmd");
        req = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] heldAddr[3];
        int          acc;

        // Reset wins over a pending request.
        reset = 1'b1;
        req = 1'b1;
        memWriteOrRead = 1'b1;
        address = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_estado", 32'(estado), 32'd0);
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;

        for (int w = 0; w < 256; w++) doCmd(1'b1, 32'(w * 4), $urandom);

        doCmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        doCmd(1'b0, 32'h0000_0010, 32'h0);
        doCmd(1'b1, 32'h0000_0044, 32'hCAFE_0001);
        doCmd(1'b1, 32'h0000_0013, 32'h5555_AAAA);
        doCmd(1'b0, 32'h0000_0010, 32'h0);
        doCmd(1'b0, 32'h0000_0400, 32'h0);
        doCmd(1'b0, 32'h8000_0000, 32'h0);

        // Reset while the write is still in WAIT: the write must be dropped.
        @(negedge clk);
        req = 1'b1;
        memWriteOrRead = 1'b1;
        address = 32'h0000_0020;
        wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("busy_before_midreset", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_ready", 32'(ready), 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        lastRd = '0;
        @(negedge clk);
        reset = 1'b0;
        doCmd(1'b0, 32'h0000_0020, 32'h0);

        // req held high across three reads: one accept every RL+2 cycles.
        heldAddr[0] = 32'h0;
        heldAddr[1] = 32'h4;
        heldAddr[2] = 32'h8;
        @(negedge clk);
        req = 1'b1;
        memWriteOrRead = 1'b0;
        address = heldAddr[0];
        acc = cyc + 1;
        for (int i = 0; i < 3; i++) expQ.push_back(predict(1'b0, heldAddr[i], 32'h0, acc + i * (RL + 2)));
        for (int i = 0; i < 3; i++) begin
            waitReady("held");
            if (i < 2) address = heldAddr[i + 1];
            else req = 1'b0;
        end
        @(posedge clk);

        for (int n = 0; n < 80; n++) begin
            case ($urandom % 8)
                0: a = ($urandom % 256) * 4 + 1 + ($urandom % 3);
                1: begin
                    a = $urandom;
                    if (a < 32'd1024) a = a + 32'd1024;
                end
                2, 3: a = ($urandom % 4) * 4;
                default: a = ($urandom % 256) * 4;
            endcase
            doCmd(1'($urandom % 2), a, $urandom);
        end

        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(posedge clk);
        check("responses_outstanding", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
